// File: rtl/csr_regfile_pkg.sv
// Shared CSR numbers, field positions, writable-bit masks and exception codes
// for the csr_regfile slice.
package csr_regfile_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_PLV_LO     = 0;
  localparam int CRMD_PLV_HI     = 1;
  localparam int CRMD_IE         = 2;
  localparam int CRMD_DA         = 3;
  localparam int PRMD_PPLV_LO    = 0;
  localparam int PRMD_PPLV_HI    = 1;
  localparam int PRMD_PIE        = 2;
  localparam int ESTAT_ECODE_LO  = 16;
  localparam int ESTAT_ECODE_HI  = 21;
  localparam int ESTAT_ESUB_LO   = 22;
  localparam int ESTAT_ESUB_HI   = 30;
  localparam int ESTAT_IS_TIMER  = 11;
  localparam int TCFG_EN         = 0;
  localparam int TCFG_PERIODIC   = 1;
  localparam int TICLR_CLR       = 0;

  localparam logic [31:0] CRMD_WMASK   = 32'h0000_000F;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  // Masked merge restricted to the bits the register actually implements.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_value,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue,
                                            input logic [31:0] writable);
    logic [31:0] m;
    m = wmask & writable;
    return (old_value & ~m) | (wvalue & m);
  endfunction

endpackage

// File: rtl/csr_regfile_timer.sv
// csr_timer: TCFG/TVAL/TICLR countdown timer; flags the 1->0 TVAL transition
// and TICLR clear requests for ESTAT.IS[11] in the register file.
module csr_timer
  import csr_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        timer_int_set,
  output logic        timer_int_clr
);

  logic [31:0] tcfg_reg;
  logic [31:0] tcfg_next;
  logic [31:0] tval_reg;
  logic [31:0] tval_next;
  logic [31:0] wbits;
  logic        tcfg_we;
  logic        load;

  assign wbits     = csr_wvalue & csr_wmask;
  assign tcfg_we   = csr_we && (csr_num == CSR_TCFG);
  assign tcfg_next = tcfg_we ? csr_merge(tcfg_reg, csr_wmask, csr_wvalue, FULL_WMASK) : tcfg_reg;
  assign load      = tcfg_we && tcfg_next[TCFG_EN];

  // A reload from a TCFG write pre-empts the final tick of an old countdown.
  assign timer_int_set = !load && tcfg_reg[TCFG_EN] && (tval_reg == 32'd1);
  assign timer_int_clr = csr_we && (csr_num == CSR_TICLR) && wbits[TICLR_CLR];

  always_comb begin
    tval_next = tval_reg;
    if (load) begin
      tval_next = {tcfg_next[31:2], 2'b00};
    end else if (tcfg_reg[TCFG_EN]) begin
      if (tval_reg != 32'd0) begin
        tval_next = tval_reg - 32'd1;
      end else if (tcfg_reg[TCFG_PERIODIC]) begin
        tval_next = {tcfg_reg[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_reg <= 32'h0;
      tval_reg <= 32'h0;
    end else begin
      tcfg_reg <= tcfg_next;
      tval_reg <= tval_next;
    end
  end

  assign tcfg = tcfg_reg;
  assign tval = tval_reg;

endmodule

// File: rtl/csr_regfile.sv
// LoongArch CSR file: writeback CSR port, exception/ertn flush, interrupts.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the timer interrupt.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [7:0]  hw_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int,
  output logic [1:0]  crmd_plv
);

  logic [31:0] crmd_reg;
  logic [31:0] prmd_reg;
  logic [31:0] ecfg_reg;
  logic [31:0] estat_reg;
  logic [7:0]  hw_int_reg;
  logic [31:0] era_reg;
  logic [31:0] badv_reg;
  logic [31:0] eentry_reg;
  logic [31:0] save_reg [4];
  logic [3:0]  save_we;
  logic [31:0] estat_value;
  logic        timer_is;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_save_we
      assign save_we[gi] = csr_we && (csr_num == (CSR_SAVE0 + 14'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_reg   <= CRMD_RESET;
      prmd_reg   <= 32'h0;
      ecfg_reg   <= 32'h0;
      estat_reg  <= 32'h0;
      hw_int_reg <= 8'h0;
      era_reg    <= 32'h0;
      badv_reg   <= 32'h0;
      eentry_reg <= 32'h0;
      for (int i = 0; i < 4; i++) save_reg[i] <= 32'h0;
    end else begin
      hw_int_reg <= hw_int_in;
      if (csr_we) begin
        case (csr_num)
          CSR_CRMD:   crmd_reg   <= csr_merge(crmd_reg, csr_wmask, csr_wvalue, CRMD_WMASK);
          CSR_PRMD:   prmd_reg   <= csr_merge(prmd_reg, csr_wmask, csr_wvalue, PRMD_WMASK);
          CSR_ECFG:   ecfg_reg   <= csr_merge(ecfg_reg, csr_wmask, csr_wvalue, ECFG_WMASK);
          CSR_ESTAT:  estat_reg  <= csr_merge(estat_reg, csr_wmask, csr_wvalue, ESTAT_WMASK);
          CSR_ERA:    era_reg    <= csr_merge(era_reg, csr_wmask, csr_wvalue, FULL_WMASK);
          CSR_BADV:   badv_reg   <= csr_merge(badv_reg, csr_wmask, csr_wvalue, FULL_WMASK);
          CSR_EENTRY: eentry_reg <= csr_merge(eentry_reg, csr_wmask, csr_wvalue, EENTRY_WMASK);
          default: ;
        endcase
      end
      for (int i = 0; i < 4; i++) begin
        if (save_we[i]) save_reg[i] <= csr_merge(save_reg[i], csr_wmask, csr_wvalue, FULL_WMASK);
      end
      // Flush assignments come last so they override a same-cycle CSR write.
      if (ertn_flush) begin
        crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO] <= prmd_reg[PRMD_PPLV_HI:PRMD_PPLV_LO];
        crmd_reg[CRMD_IE]                 <= prmd_reg[PRMD_PIE];
      end else if (excp_flush) begin
        prmd_reg[PRMD_PPLV_HI:PRMD_PPLV_LO] <= crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO];
        prmd_reg[PRMD_PIE]                  <= crmd_reg[CRMD_IE];
        crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO]   <= 2'b00;
        crmd_reg[CRMD_IE]                   <= 1'b0;
        era_reg                             <= wb_pc;
        estat_reg[ESTAT_ECODE_HI:ESTAT_ECODE_LO] <= wb_ecode;
        estat_reg[ESTAT_ESUB_HI:ESTAT_ESUB_LO]   <= wb_esubcode;
      end
    end
  end

`ifdef CSR_TIMER_EN
  logic [31:0] tid_reg;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        timer_int_set;
  logic        timer_int_clr;
  logic        timer_is_reg;

  csr_timer u_timer (
    .clk           (clk),
    .reset         (reset),
    .csr_we        (csr_we),
    .csr_num       (csr_num),
    .csr_wmask     (csr_wmask),
    .csr_wvalue    (csr_wvalue),
    .tcfg          (tcfg),
    .tval          (tval),
    .timer_int_set (timer_int_set),
    .timer_int_clr (timer_int_clr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tid_reg      <= TID_RESET;
      timer_is_reg <= 1'b0;
    end else begin
      if (csr_we && (csr_num == CSR_TID)) begin
        tid_reg <= csr_merge(tid_reg, csr_wmask, csr_wvalue, FULL_WMASK);
      end
      if (timer_int_set) begin
        timer_is_reg <= 1'b1;
      end else if (timer_int_clr) begin
        timer_is_reg <= 1'b0;
      end
    end
  end

  assign timer_is = timer_is_reg;
`else
  // TID_RESET has no effect without the timer; the AND keeps IS[11] at 0.
  assign timer_is = &{1'b0, TID_RESET[0]};
`endif

  // IS[12] and IS[10] are hard-wired to 0.
  assign estat_value = estat_reg | {19'b0, 1'b0, timer_is, 1'b0, hw_int_reg, 2'b00};

  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = crmd_reg;
      CSR_PRMD:   csr_rvalue = prmd_reg;
      CSR_ECFG:   csr_rvalue = ecfg_reg;
      CSR_ESTAT:  csr_rvalue = estat_value;
      CSR_ERA:    csr_rvalue = era_reg;
      CSR_BADV:   csr_rvalue = badv_reg;
      CSR_EENTRY: csr_rvalue = eentry_reg;
      CSR_SAVE0:  csr_rvalue = save_reg[0];
      CSR_SAVE1:  csr_rvalue = save_reg[1];
      CSR_SAVE2:  csr_rvalue = save_reg[2];
      CSR_SAVE3:  csr_rvalue = save_reg[3];
`ifdef CSR_TIMER_EN
      CSR_TID:    csr_rvalue = tid_reg;
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = tval;
`endif
      default:    csr_rvalue = 32'h0;
    endcase
  end

  assign has_int  = crmd_reg[CRMD_IE] & (|(estat_value[12:0] & ecfg_reg[12:0]));
  assign ex_entry = eentry_reg;
  assign era_pc   = era_reg;
  assign crmd_plv = crmd_reg[CRMD_PLV_HI:CRMD_PLV_LO];

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile; timer steps run only when
// CSR_TIMER_EN is defined, otherwise the timer addresses must read 0.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [7:0]  hw_int_in;
  logic [31:0] ex_entry;
  logic [31:0] era_pc;
  logic        has_int;
  logic [1:0]  crmd_plv;

  int n_vec = 0;
  int n_err = 0;

  csr_regfile dut (
    .clk         (clk),
    .reset       (reset),
    .csr_rnum    (csr_rnum),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_num     (csr_num),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .excp_flush  (excp_flush),
    .ertn_flush  (ertn_flush),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .hw_int_in   (hw_int_in),
    .ex_entry    (ex_entry),
    .era_pc      (era_pc),
    .has_int     (has_int),
    .crmd_plv    (crmd_plv)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic [13:0] num, input logic [31:0] exp);
    csr_rnum = num;
    #1;
    check(tag, csr_rvalue, exp);
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; csr_rnum = '0; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
    excp_flush = 1'b0; ertn_flush = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0;
    hw_int_in = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk_csr("rst_crmd", 14'h0, 32'h8);
    chk_csr("rst_estat", 14'h5, 32'h0);
    check("rst_ex_entry", ex_entry, 32'h0);
    check("rst_has_int", {31'b0, has_int}, 32'h0);
    check("rst_era_pc", era_pc, 32'h0);
    check("rst_plv", {30'b0, crmd_plv}, 32'h0);
    chk_csr("rst_unimpl_tval", 14'h42, 32'h0);

    // EENTRY drops VA[5:0]
    wr(14'h00C, 32'hFFFFFFFF, 32'h1C008123);
    chk_csr("eentry_rd", 14'h00C, 32'h1C008100);
    check("ex_entry", ex_entry, 32'h1C008100);

    // exception entry from PLV3/IE1
    wr(14'h0, 32'hFFFFFFFF, 32'h7);
    chk_csr("crmd_wr", 14'h0, 32'h7);
    check("plv3", {30'b0, crmd_plv}, 32'h3);
    excp_flush = 1'b1; wb_pc = 32'h1C000040; wb_ecode = 6'hB; wb_esubcode = 9'h0;
    #1;
    check("ex_entry_in_flush", ex_entry, 32'h1C008100);
    tick();
    excp_flush = 1'b0;
    chk_csr("excp_crmd", 14'h0, 32'h0);
    check("excp_plv", {30'b0, crmd_plv}, 32'h0);
    chk_csr("excp_prmd", 14'h1, 32'h7);
    chk_csr("excp_era", 14'h6, 32'h1C000040);
    check("excp_era_pc", era_pc, 32'h1C000040);
    chk_csr("excp_estat", 14'h5, 32'h000B0000);
    check("ex_entry_after", ex_entry, 32'h1C008100);

    // ertn alone restores PLV/IE
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    chk_csr("ertn_crmd", 14'h0, 32'h7);

    // excp+ertn together: ertn only
    wr(14'h0, 32'hFFFFFFFF, 32'h1);
    excp_flush = 1'b1; ertn_flush = 1'b1; wb_pc = 32'h12345678; wb_ecode = 6'h3;
    tick();
    excp_flush = 1'b0; ertn_flush = 1'b0;
    chk_csr("both_crmd", 14'h0, 32'h7);
    chk_csr("both_prmd", 14'h1, 32'h7);
    check("both_era", era_pc, 32'h1C000040);
    chk_csr("both_estat", 14'h5, 32'h000B0000);

    // BADV write alongside an ALE exception
    excp_flush = 1'b1; wb_pc = 32'h1C000080; wb_ecode = 6'h9; wb_esubcode = 9'h0;
    wr(14'h7, 32'hFFFFFFFF, 32'hDEAD0001);
    excp_flush = 1'b0;
    chk_csr("badv_flush", 14'h7, 32'hDEAD0001);
    check("badv_era", era_pc, 32'h1C000080);
    chk_csr("badv_crmd", 14'h0, 32'h0);
    chk_csr("badv_estat", 14'h5, 32'h00090000);

    // ERA write loses to flush
    excp_flush = 1'b1; wb_pc = 32'h1C0000C0; wb_ecode = 6'h8; wb_esubcode = 9'h1;
    wr(14'h6, 32'hFFFFFFFF, 32'h11111111);
    excp_flush = 1'b0;
    check("era_flush_wins", era_pc, 32'h1C0000C0);
    chk_csr("prmd_from_plv0", 14'h1, 32'h0);
    chk_csr("estat_subcode", 14'h5, 32'h00480000);

    // masked writes and writable-bit filtering
    wr(14'h4, 32'h0000FFFF, 32'hFFFFFFFF);
    chk_csr("ecfg_lie", 14'h4, 32'h00001BFF);
    wr(14'h4, 32'h00000003, 32'h0);
    chk_csr("ecfg_mask", 14'h4, 32'h00001BFC);
    wr(14'h5, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk_csr("estat_is10", 14'h5, 32'h00480003);

    // interrupts: SWI masked, HWI0 enabled with one cycle latency
    wr(14'h0, 32'hFFFFFFFF, 32'h4);
    check("swi_masked", {31'b0, has_int}, 32'h0);
    hw_int_in = 8'h01;
    #1;
    check("hwi_not_yet", {31'b0, has_int}, 32'h0);
    tick();
    check("hwi_int", {31'b0, has_int}, 32'h1);
    chk_csr("hwi_estat", 14'h5, 32'h00480007);
    hw_int_in = 8'h00;
    tick();
    check("hwi_drop", {31'b0, has_int}, 32'h0);

    // SAVE0-3 and unimplemented numbers
    for (int i = 0; i < 4; i++) wr(14'h30 + 14'(i), 32'hFFFFFFFF, 32'hA5A50000 + 32'(i));
    for (int i = 0; i < 4; i++) chk_csr($sformatf("save%0d", i), 14'h30 + 14'(i), 32'hA5A50000 + 32'(i));
    wr(14'h2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk_csr("unimpl_2", 14'h2, 32'h0);

    // timer setup: LIE[11] only, IE=1, IS[1:0] cleared
    wr(14'h5, 32'h00000003, 32'h0);
    wr(14'h4, 32'hFFFFFFFF, 32'h00000800);
    chk_csr("ecfg_ti", 14'h4, 32'h00000800);
    check("ti_idle", {31'b0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
    chk_csr("tid_rst", 14'h40, 32'h0);
    wr(14'h40, 32'hFFFFFFFF, 32'h12345678);
    chk_csr("tid_wr", 14'h40, 32'h12345678);
    wr(14'h41, 32'hFFFFFFFF, 32'h0000000B);
    chk_csr("tcfg", 14'h41, 32'h0000000B);
    chk_csr("tval_load", 14'h42, 32'h8);
    repeat (7) tick();
    check("ti_before", {31'b0, has_int}, 32'h0);
    chk_csr("tval_one", 14'h42, 32'h1);
    tick();
    check("ti_rise", {31'b0, has_int}, 32'h1);
    chk_csr("tval_zero", 14'h42, 32'h0);
    chk_csr("estat_ti", 14'h5, 32'h00480800);
    tick();
    chk_csr("tval_reload", 14'h42, 32'h8);
    wr(14'h44, 32'hFFFFFFFF, 32'h1);
    check("ticlr", {31'b0, has_int}, 32'h0);
    chk_csr("ticlr_rd", 14'h44, 32'h0);
    chk_csr("tval_after_clr", 14'h42, 32'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_csr("rst_tval", 14'h42, 32'h0);
    chk_csr("rst_tcfg", 14'h41, 32'h0);
    chk_csr("rst_estat2", 14'h5, 32'h0);
`else
    wr(14'h41, 32'hFFFFFFFF, 32'h0000000B);
    chk_csr("notimer_tcfg", 14'h41, 32'h0);
    chk_csr("notimer_tval", 14'h42, 32'h0);
    wr(14'h40, 32'hFFFFFFFF, 32'h12345678);
    chk_csr("notimer_tid", 14'h40, 32'h0);
    repeat (10) tick();
    check("notimer_int", {31'b0, has_int}, 32'h0);
    chk_csr("notimer_estat", 14'h5, 32'h00480000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    chk_csr("rst2_crmd", 14'h0, 32'h8);
    check("rst2_has_int", {31'b0, has_int}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
